// File: rtl/io_pkg.sv
// Shared constants and elaboration helpers for the io_port_bank channel FIFOs.
package io_pkg;

  localparam int IO_DATA_WIDTH = 32;
  localparam int IO_MAX_CH     = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // LSB position of channel ch inside a flattened NUM_CH*width bus.
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Single-clock FIFO with MSB-differs full detection and a registered-storage head.
// No fall-through: a pushed word becomes visible at rd_data on the following cycle.
module io_fifo
  import io_pkg::*;
#(
  parameter int DATA_WIDTH = IO_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);

  localparam int AW = clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A push at full is accepted only when a pop frees the slot in the same edge.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/io_port_bank.sv
// Bank of NUM_CH input and NUM_CH output FIFO channels behind the bus inport/outport strobes.
// Optional sticky per-channel error flags are built when IO_ERR_EN is defined.
module io_port_bank
  import io_pkg::*;
#(
  parameter int DATA_WIDTH = IO_DATA_WIDTH,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CH_SEL_W   = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [CH_SEL_W-1:0]          ch_sel,
  input  logic                         inport_out,
  output logic [DATA_WIDTH-1:0]        inport_data,
  input  logic                         outport_in,
  input  logic [DATA_WIDTH-1:0]        bus_data,
  output logic                         io_stall,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ext_in_data,
  input  logic [NUM_CH-1:0]            ext_in_valid,
  output logic [NUM_CH-1:0]            ext_in_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] ext_out_data,
  output logic [NUM_CH-1:0]            ext_out_valid,
  input  logic [NUM_CH-1:0]            ext_out_ready,
  output logic [NUM_CH-1:0]            in_empty,
  output logic [NUM_CH-1:0]            out_full,
  output logic [NUM_CH-1:0]            io_err,
  input  logic                         err_clr
);

  logic [NUM_CH-1:0]                 w_in_push;
  logic [NUM_CH-1:0]                 w_in_pop;
  logic [NUM_CH-1:0]                 w_in_full;
  logic [NUM_CH-1:0]                 w_out_push;
  logic [NUM_CH-1:0]                 w_out_pop;
  logic [NUM_CH-1:0]                 w_out_empty;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_in_head;
  logic                              r_rdy_en;

  // Holds ext_in_ready low through the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rdy_en <= 1'b0;
    else          r_rdy_en <= 1'b1;
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_in_push[i]     = ext_in_valid[i] & ext_in_ready[i];
      assign w_in_pop[i]      = inport_out & (ch_sel == CH_SEL_W'(i));
      assign w_out_push[i]    = outport_in & (ch_sel == CH_SEL_W'(i));
      assign w_out_pop[i]     = ext_out_valid[i] & ext_out_ready[i];
      assign ext_in_ready[i]  = r_rdy_en & ~w_in_full[i];
      assign ext_out_valid[i] = ~w_out_empty[i];

      io_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_in_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_in_push[i]),
        .pop     (w_in_pop[i]),
        .wr_data (ext_in_data[ch_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
        .rd_data (w_in_head[i]),
        .empty   (in_empty[i]),
        .full    (w_in_full[i])
      );

      io_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_out_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_out_push[i]),
        .pop     (w_out_pop[i]),
        .wr_data (bus_data),
        .rd_data (ext_out_data[ch_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
        .empty   (w_out_empty[i]),
        .full    (out_full[i])
      );
    end
  endgenerate

  // An out-of-range ch_sel matches no channel, so data reads 0 and no stall is raised.
  always_comb begin
    inport_data = '0;
    io_stall    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_SEL_W'(i)) begin
        if (!in_empty[i]) inport_data = w_in_head[i];
        io_stall = (inport_out & in_empty[i]) | (outport_in & out_full[i]);
      end
    end
  end

`ifdef IO_ERR_EN
  localparam logic [CH_SEL_W:0] NUM_CH_SEL = (CH_SEL_W+1)'(NUM_CH);

  logic              w_sel_ok;
  logic [NUM_CH-1:0] w_err_set;
  logic [NUM_CH-1:0] r_err;

  assign w_sel_ok = ({1'b0, ch_sel} < NUM_CH_SEL);

  // A write at full that coincides with an external pop is accepted, hence not an error.
  always_comb begin
    w_err_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_SEL_W'(i)) begin
        w_err_set[i] = (inport_out & in_empty[i]) |
                       (outport_in & out_full[i] & ~w_out_pop[i]);
      end
    end
    if (!w_sel_ok && (inport_out || outport_in)) w_err_set[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_err <= '0;
    else if (err_clr) r_err <= w_err_set;
    else              r_err <= r_err | w_err_set;
  end

  assign io_err = r_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign io_err           = '0;
`endif

endmodule
